// File: rtl/debounce_multi.sv
// N-channel switch debouncer: 2-FF synchronizer, bounce/stable FSM with shared timeout,
// per-edge lock and per-channel unlock. Define DEBOUNCE_GLITCH_CNT_EN for per-channel glitch counters.
module debounce_multi #(
    parameter int                  CHANNELS = 4,
    parameter int                  TIMER_W  = 16,
    parameter logic [CHANNELS-1:0] INIT_VAL = '0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [CHANNELS-1:0]     signal_in,
    input  logic [TIMER_W-1:0]      timeout,
    input  logic [CHANNELS-1:0]     lock_rise_en,
    input  logic [CHANNELS-1:0]     lock_fall_en,
    input  logic [CHANNELS-1:0]     unlock,
    output logic [CHANNELS-1:0]     signal,
    output logic [CHANNELS-1:0]     hold,
    output logic [CHANNELS-1:0]     stb,
    output logic [CHANNELS-1:0]     locked,
    output logic                    any_stb,
    output logic [CHANNELS*8-1:0]   glitch_cnt
);
    typedef enum logic [1:0] {S_STABLE, S_BOUNCE1, S_BOUNCE2, S_LOCKED} state_t;

    logic [CHANNELS-1:0] sync_q1, sync_q2, stb_nxt;

    // Synchronizer flops carry no reset so they stay plain metastability filters
    always_ff @(posedge clk) begin
        sync_q1 <= signal_in;
        sync_q2 <= sync_q1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) any_stb <= 1'b0;
        else          any_stb <= |stb_nxt;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t             state;
        logic [TIMER_W-1:0] timer;
        logic               s, v, hold_q, stb_q, lock_q, stb_n, expired;

        assign s       = sync_q2[i];
        assign expired = timer >= timeout;

        always_comb begin
            stb_n = 1'b0;
            case (state)
                S_BOUNCE1: stb_n = (s != v) && expired;
                S_LOCKED:  stb_n = unlock[i] && (s != v);
                default:   stb_n = 1'b0;
            endcase
        end

`ifdef DEBOUNCE_GLITCH_CNT_EN
        logic [7:0] gcnt;
`endif

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                state  <= S_STABLE;
                timer  <= '0;
                v      <= INIT_VAL[i];
                hold_q <= 1'b0;
                stb_q  <= 1'b0;
                lock_q <= 1'b0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
                gcnt   <= '0;
`endif
            end else begin
                hold_q <= 1'b0;
                stb_q  <= stb_n;
                case (state)
                    S_STABLE: begin
                        if (s != v) begin
                            state  <= S_BOUNCE1;
                            timer  <= '0;
                            hold_q <= 1'b1;
                        end
                    end
                    S_BOUNCE1: begin
                        if (s == v) begin
                            state <= S_BOUNCE2;
                            timer <= '0;
                        end else if (expired) begin
                            v     <= s;
                            timer <= '0;
                            // Lock policy is looked at only on the commit edge
                            if ((s && lock_rise_en[i]) || (!s && lock_fall_en[i])) begin
                                state  <= S_LOCKED;
                                lock_q <= 1'b1;
                            end else begin
                                state <= S_STABLE;
                            end
                        end else begin
                            timer <= timer + TIMER_W'(1);
                        end
                    end
                    S_BOUNCE2: begin
                        if (s != v) begin
                            state <= S_BOUNCE1;
                            timer <= '0;
                        end else if (expired) begin
                            state <= S_STABLE;
                            timer <= '0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
                            if (gcnt != 8'hff) gcnt <= gcnt + 8'd1;
`endif
                        end else begin
                            timer <= timer + TIMER_W'(1);
                        end
                    end
                    S_LOCKED: begin
                        if (unlock[i]) begin
                            v      <= s;
                            state  <= S_STABLE;
                            lock_q <= 1'b0;
                        end
                    end
                    default: state <= S_STABLE;
                endcase
            end
        end

        assign stb_nxt[i] = stb_n;
        assign signal[i]  = v;
        assign hold[i]    = hold_q;
        assign stb[i]     = stb_q;
        assign locked[i]  = lock_q;
`ifdef DEBOUNCE_GLITCH_CNT_EN
        assign glitch_cnt[8*i +: 8] = gcnt;
`else
        assign glitch_cnt[8*i +: 8] = 8'h00;
`endif
    end
endmodule
